// File: rtl/pipe_hazard_ctl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall, branch flush, memory freeze.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_uses_rt,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic [1:0]  state,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  state_t     cur_state, nxt_state;
  logic [3:0] flush_left, flush_left_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err_set;
  logic       hz;

  assign hz = idex_memread && (idex_rt != 5'd0) &&
              ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  assign state = cur_state;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    pipe_freeze    = 1'b0;
    nxt_state      = cur_state;
    flush_left_nxt = flush_left;
    wait_cnt_nxt   = wait_cnt;
    err_set        = 1'b0;

    unique case (cur_state)
      RUN, LDUSE: begin
        nxt_state = RUN;
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            nxt_state      = FLUSH;
            flush_left_nxt = 4'(FLUSH_CYCLES - 1);
          end
        end else if (mem_busy) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          pipe_freeze  = 1'b1;
          wait_cnt_nxt = 8'd1;
          nxt_state    = MEMWAIT;
        end else if (hz && (cur_state == RUN)) begin
          // The stalled instruction re-evaluates in LDUSE, where hz is masked.
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          nxt_state   = LDUSE;
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          pipe_freeze = 1'b1;
        end else begin
          ifid_flush     = 1'b1;
          idex_bubble    = 1'b1;
          flush_left_nxt = flush_left - 4'd1;
          if (flush_left == 4'd1) nxt_state = RUN;
        end
      end
      MEMWAIT: begin
        if (mem_busy && (wait_cnt == 8'(MEM_TIMEOUT - 1))) begin
          err_set      = 1'b1;
          wait_cnt_nxt = 8'd0;
          nxt_state    = RUN;
        end else if (mem_busy) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          pipe_freeze  = 1'b1;
          wait_cnt_nxt = wait_cnt + 8'd1;
        end else begin
          wait_cnt_nxt = 8'd0;
          nxt_state    = RUN;
        end
      end
      default: nxt_state = RUN;
    endcase

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      cur_state  <= RUN;
      flush_left <= 4'd0;
      wait_cnt   <= 8'd0;
      mem_err    <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      flush_left <= flush_left_nxt;
      wait_cnt   <= wait_cnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_write) stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken && ((cur_state == RUN) || (cur_state == LDUSE)))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Drives PC write-enable, IF/ID write and flush, and the ID/EX bubble select (zeros wb/m/ex control into the ID/EX register).
- Drives a global freeze for data-memory wait states.
- Detects load-use hazards, branch-taken flushes and memory stalls, and sequences them with a small FSM.

Parameters:
FLUSH_CYCLES, 2, total cycles of flush after a taken branch (1..15)
MEM_TIMEOUT, 64, max consecutive mem_busy cycles before abort and error (2..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
idex_memread  in  1  ID/EX m-control memread bit (instruction in EX is a load)
idex_rt  in  5  ID/EX rt field (load destination)
ifid_rs  in  5  rs of instruction in ID
ifid_rt  in  5  rt of instruction in ID
ifid_uses_rt  in  1  ID instruction reads rt as a source
branch_taken  in  1  branch resolved taken this cycle
mem_busy  in  1  data memory not ready
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_bubble  out  1  select zero controls into ID/EX
pipe_freeze  out  1  hold EX/MEM and MEM/WB
state  out  2  FSM state: RUN=0, LDUSE=1, FLUSH=2, MEMWAIT=3
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  32  stall cycle counter (optional feature)
flush_cnt  out  32  branch flush event counter (optional feature)

Behaviour:
- Only state, counters and mem_err are registered. Control outputs are Mealy: combinational from state and current inputs, zero latency.
- Default (normal) outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0.
- Hazard term: hz = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt)).
- Reset: the edge with rst_n=0 sets state=RUN, flush counter=0, timeout counter=0, mem_err=0, perf counters=0.
- While rst_n=0, outputs are forced to: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0.
- Reset mid-flush or mid-wait aborts to RUN; the operation is not resumed.
- RUN, priority branch_taken > mem_busy > hz:
  - branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  - mem_busy: pc_write=0, ifid_write=0, pipe_freeze=1, timeout counter=1, go to MEMWAIT.
  - hz: pc_write=0, ifid_write=0, idex_bubble=1, go to LDUSE.
  - None of these: normal outputs.
- LDUSE: exactly one cycle, then RUN. hz is masked. branch_taken and mem_busy are handled exactly as in RUN (same outputs and transitions); otherwise normal outputs.
- FLUSH:
  - Outputs: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1.
  - cnt decrements each cycle; go to RUN on the cycle cnt==1.
  - branch_taken is ignored (wrong-path branch).
  - mem_busy has priority: freeze outputs, cnt held, state stays FLUSH.
- MEMWAIT:
  - While mem_busy=1: pc_write=0, ifid_write=0, pipe_freeze=1; timeout counter increments.
  - If the counter reaches MEM_TIMEOUT while mem_busy=1: set mem_err=1 (sticky until reset), go to RUN, normal outputs that cycle.
  - mem_busy=0: normal outputs that cycle, go to RUN, counter cleared.
  - branch_taken in MEMWAIT is ignored; the resolving stage is frozen.
- Simultaneous branch_taken and hz in RUN: flush wins; the load-use stall is discarded because the ID instruction is flushed.
- Register 0 never creates a hazard.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with rst_n=1 and pc_write=0.
  - flush_cnt increments on each accepted branch_taken, i.e. transition into FLUSH or a single-cycle flush in RUN/LDUSE.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: stall_cnt and flush_cnt are constant 0 and no counter flops are generated.

Test Plan:
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8. Required: pc_write=0, ifid_write=0, idex_bubble=1 for one cycle; state RUN→LDUSE→RUN; normal outputs next cycle.
- No hazard: idex_rt=0 with ifid_rs=0 → normal outputs. idex_rt=9, ifid_rt=9, ifid_uses_rt=0 → normal outputs.
- Branch: branch_taken=1 in RUN with FLUSH_CYCLES=2 → ifid_flush=1 and idex_bubble=1 for exactly 2 cycles, state 0→2→0. A branch_taken pulse during FLUSH causes no extension.
- Memory wait: mem_busy high for 5 cycles → pipe_freeze=1 and pc_write=0 for 5 cycles, normal on the 6th cycle, mem_err=0.
- Timeout: MEM_TIMEOUT=8, mem_busy held high → mem_err=1 after 8 busy cycles, state=RUN; mem_err stays 1 until rst_n=0.
- Priority and reset: branch_taken, mem_busy and hz all asserted in RUN → flush outputs. rst_n=0 mid-MEMWAIT → state=0 next edge, counters 0. With HAZ_PERF_CNT_EN, stall_cnt=6 after the 5-cycle wait plus one load-use stall.
